// File: rtl/paridade_pkg.sv
`default_nettype none
// ============================================================================
// Module      : paridade_pkg
// Description : Shared types and helpers for the 5-bit + parity link.
//               Holds the transmitter state encoding, frame geometry and
//               the parity function used by both ends of the link.
// Contents    : state_t      - transmitter FSM states
//               FRAME_BITS   - serial bits per frame (start+5 data+parity+stop)
//               DATA_BITS    - payload width
//               calc_parity  - parity bit for a word (even when odd=0)
// Revision    : 1.0 - initial release
// ============================================================================
package paridade_pkg;

  localparam int FRAME_BITS = 8;
  localparam int DATA_BITS  = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Returns P such that ^{data, P} == odd.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage : paridade_pkg
`default_nettype wire

// File: rtl/paridade_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : paridade_baud_gen
// Description : Bit-period counter for the parity-word serializer. Counts
//               0..CLKS_PER_BIT-1 while enabled and flags the last cycle of
//               each bit period.
// Ports       : clk       in  clock, rising edge
//               rst_n     in  synchronous active-low reset
//               clear     in  restart the bit period (counter to 0)
//               enable    in  count this cycle
//               bit_tick  out high on the last cycle of a bit period
// Revision    : 1.0 - initial release
// ============================================================================
module paridade_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int            CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last   = (r_cnt == CNT_LAST);
  assign bit_tick = enable && w_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule : paridade_baud_gen
`default_nettype wire

// File: rtl/paridade_tx.sv
`default_nettype none
// ============================================================================
// Module      : paridade_tx
// Description : Parity-word transmitter. Accepts a 5-bit word over a
//               valid/ready handshake, computes its parity bit, presents
//               word and parity as registered parallel outputs and
//               serializes start, B1..B5, parity, stop on tx_serial.
// Parameters  : CLKS_PER_BIT - clocks per serial bit (>= 2)
//               ODD_PARITY   - 0 even, 1 odd parity
// Ports       : clk          in  clock, rising edge
//               rst_n        in  synchronous active-low reset
//               data_in[4:0] in  word, data_in[4]=B1 .. data_in[0]=B5
//               data_valid   in  word present
//               force_err    in  invert parity of the accepted word
//               data_ready   out high while idle
//               B1..B5       out registered parallel word
//               bitparidade  out registered parity bit
//               tx_serial    out serial line, idles high
//               busy         out frame in progress
//               done         out one-cycle pulse after the stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module paridade_tx
  import paridade_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit ODD_PARITY   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  input  logic                 force_err,
  output logic                 data_ready,
  output logic                 B1,
  output logic                 B2,
  output logic                 B3,
  output logic                 B4,
  output logic                 B5,
  output logic                 bitparidade,
  output logic                 tx_serial,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_idx;
  logic [2:0]           w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_word;
  logic                 r_par;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_busy;
  logic                 r_ready;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 w_shift;
  logic                 w_accept;
  logic                 w_tick;

  assign w_accept = data_valid && r_ready;

  paridade_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_accept),
    .enable   (r_state != IDLE),
    .bit_tick (w_tick)
  );

  // Next-state and next-output logic. tx_serial is registered, so the value
  // computed here is the one the line carries in the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_idx_nxt   = 3'd0;
          w_tx_nxt    = r_shift[DATA_BITS-1];
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_idx == IDX_LAST) begin
            w_state_nxt = PARITY;
            w_tx_nxt    = r_par;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_shift   = 1'b1;
            // Bit that becomes the MSB after this cycle's shift.
            w_tx_nxt  = r_shift[DATA_BITS-2];
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_shift <= '0;
      r_word  <= '0;
      r_par   <= ODD_PARITY;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_ready <= (w_state_nxt == IDLE);
      if (w_accept) begin
        r_word  <= data_in;
        r_shift <= data_in;
        r_par   <= calc_parity(data_in, ODD_PARITY) ^ force_err;
      end else if (w_shift) begin
        r_shift <= {r_shift[DATA_BITS-2:0], 1'b0};
      end
    end
  end

  assign data_ready  = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign tx_serial   = r_tx;
  assign bitparidade = r_par;
  assign B1          = r_word[4];
  assign B2          = r_word[3];
  assign B3          = r_word[2];
  assign B4          = r_word[1];
  assign B5          = r_word[0];

endmodule : paridade_tx
`default_nettype wire

// File: tb/tb_paridade_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_paridade_tx
// Description : Directed self-checking bench for paridade_tx. Two instances
//               share the stimulus: one even-parity, one odd-parity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paridade_tx;
  import paridade_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] data_in;
  logic       data_valid;
  logic       force_err;

  logic e_ready, e_b1, e_b2, e_b3, e_b4, e_b5, e_par, e_tx, e_busy, e_done;
  logic o_ready, o_b1, o_b2, o_b3, o_b4, o_b5, o_par, o_tx, o_busy, o_done;
  logic [4:0] e_word;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign e_word = {e_b1, e_b2, e_b3, e_b4, e_b5};

  paridade_tx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1'b0)) u_dut_even (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .force_err(force_err), .data_ready(e_ready),
    .B1(e_b1), .B2(e_b2), .B3(e_b3), .B4(e_b4), .B5(e_b5),
    .bitparidade(e_par), .tx_serial(e_tx), .busy(e_busy), .done(e_done)
  );

  paridade_tx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1'b1)) u_dut_odd (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .force_err(force_err), .data_ready(o_ready),
    .B1(o_b1), .B2(o_b2), .B3(o_b3), .B4(o_b4), .B5(o_b5),
    .bitparidade(o_par), .tx_serial(o_tx), .busy(o_busy), .done(o_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in the first cycle after the accept edge; returns in the done cycle.
  task automatic run_frame(input logic [4:0] w, input logic p);
    logic [7:0] seq;
    seq = {1'b0, w, p, 1'b1};
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("tx b%0d c%0d", b, c), e_tx, seq[7-b]);
        chk($sformatf("done_low b%0d c%0d", b, c), e_done, 1'b0);
        if (c == 0) begin
          chk($sformatf("word_hold b%0d", b), e_word, w);
          chk($sformatf("busy b%0d", b), e_busy, 1'b1);
          chk($sformatf("ready_low b%0d", b), e_ready, 1'b0);
        end
        step();
      end
    end
    chk("done_pulse", e_done, 1'b1);
    chk("done_ready", e_ready, 1'b1);
    chk("done_busy", e_busy, 1'b0);
    chk("done_tx", e_tx, 1'b1);
    chk("done_word", e_word, w);
  endtask

  initial begin
    logic saw_done;
    rst_n      = 1'b0;
    data_valid = 1'b1;
    data_in    = 5'b10110;
    force_err  = 1'b0;

    // Reset with a word pending: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", e_ready, 1'b1);
      chk("rst_tx", e_tx, 1'b1);
      chk("rst_busy", e_busy, 1'b0);
      chk("rst_done", e_done, 1'b0);
      chk("rst_word", e_word, 5'b00000);
      chk("rst_par_even", e_par, 1'b0);
      chk("rst_par_odd", o_par, 1'b1);
    end

    // First edge with rst_n high accepts 10110 (three ones).
    rst_n = 1'b1;
    step();
    data_valid = 1'b0;
    chk("f1_par_even", e_par, 1'b1);
    chk("f1_par_odd", o_par, 1'b0);
    run_frame(5'b10110, 1'b1);
    step();
    chk("f1_done_cleared", e_done, 1'b0);

    // All-zero word.
    data_in    = 5'b00000;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    chk("zero_par_even", e_par, 1'b0);
    chk("zero_par_odd", o_par, 1'b1);
    run_frame(5'b00000, 1'b0);
    step();

    // Error injection on all-ones: parity inverted, receiver sees invalid.
    data_in    = 5'b11111;
    data_valid = 1'b1;
    force_err  = 1'b1;
    step();
    data_valid = 1'b0;
    force_err  = 1'b0;
    chk("err_par_even", e_par, 1'b0);
    chk("err_par_odd", o_par, 1'b1);
    chk("err_invalid", ((^e_word) ^ e_par) != 1'b0, 1'b1);
    run_frame(5'b11111, 1'b0);
    step();

    // Back-to-back: valid held, second word accepted in the done cycle.
    data_in    = 5'b01001;
    data_valid = 1'b1;
    step();
    data_in = 5'b11100;
    chk("b2b1_par", e_par, 1'b0);
    run_frame(5'b01001, 1'b0);
    step();
    data_valid = 1'b0;
    chk("b2b2_par", e_par, 1'b1);
    chk("b2b2_start_tx", e_tx, 1'b0);
    run_frame(5'b11100, 1'b1);
    step();

    // Reset during data bit B4 aborts the frame.
    data_in    = 5'b10110;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("abort_pre_tx", e_tx, 1'b1);
    chk("abort_pre_busy", e_busy, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_tx", e_tx, 1'b1);
    chk("abort_ready", e_ready, 1'b1);
    chk("abort_busy", e_busy, 1'b0);
    chk("abort_word", e_word, 5'b00000);
    chk("abort_par_even", e_par, 1'b0);
    chk("abort_par_odd", o_par, 1'b1);
    chk("abort_done", e_done, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (e_done || o_done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 1'b0);
    chk("abort_idle_tx", e_tx, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_paridade_tx
`default_nettype wire
